add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: N, default 32, operand and sum width of the shared ripple-carry adder.
REQ-002 Parameter: NREQ, fixed at 4, number of requesters; only value 4 SHALL be supported.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  4  per-requester request valid.
REQ-007 req_ready  output  4  per-requester accept strobe; one-hot or zero.
REQ-008 req_a  input  4*N  packed operand A; requester k at bits [k*N +: N].
REQ-009 req_b  input  4*N  packed operand B; same packing.
REQ-010 req_cin  input  4  per-requester carry-in.
REQ-011 rsp_valid  output  1  result valid.
REQ-012 rsp_ready  input  1  result consumer ready.
REQ-013 rsp_id  output  2  index of the granted requester.
REQ-014 rsp_sum  output  N  (a + b + cin) mod 2^N.
REQ-015 rsp_cout  output  1  carry out of bit N-1.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The block SHALL contain exactly one instance of the team's add_all adder, time-shared among all requesters.
REQ-018 FSM states: IDLE, EXEC, RESP; encoding is free.
REQ-019 IDLE: if any req_valid is high, the block SHALL grant the first valid requester at or after rr_ptr (mod 4), assert req_ready[grant] combinationally in that cycle, latch a, b, cin and grant id, and move to EXEC.
REQ-020 IDLE with no req_valid: req_ready = 0; stay in IDLE.
REQ-021 req_ready SHALL be 0 in EXEC and RESP.
REQ-022 EXEC: the latched operands drive the adder; sum and cout SHALL be registered at the end of the cycle; next state RESP.
REQ-023 RESP: rsp_valid = 1; rsp_id, rsp_sum and rsp_cout SHALL be held stable until rsp_valid && rsp_ready.
REQ-024 On the RESP handshake: rr_ptr <= (grant + 1) mod 4; next state IDLE.
REQ-025 Latency: accept at cycle T gives rsp_valid at T+2; minimum issue interval is 3 cycles.
REQ-026 Requester protocol: hold req_valid and operands stable until req_ready; the block samples only in the accept cycle.
REQ-027 Operand changes after accept SHALL NOT affect the result in flight.
REQ-028 Arithmetic: no overflow flag; wrap mod 2^N, with carry reported only on rsp_cout.
REQ-029 rsp_valid and rsp_ready high in the same RESP cycle: completes the handshake; IDLE is reached next cycle and no request is accepted in that RESP cycle.
REQ-030 A request dropped before its accept SHALL NOT be granted.

Reset
REQ-031 When rst is high at a clock edge: state IDLE, rr_ptr 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0, busy 0, and operand/grant registers 0.
REQ-032 req_ready SHALL be 0 in any cycle rst is high.
REQ-033 Reset in EXEC or RESP SHALL abandon the transaction with no response; a requester still holding valid SHALL be re-arbitrated from rr_ptr 0.

Verification
REQ-034 Only req_valid[0], a=5, b=7, cin=0 -> req_ready[0] at T; rsp_valid at T+2 with id 0, sum 12, cout 0.
REQ-035 Boundary sums -> a=FFFFFFFF, b=1, cin=0 gives sum 0, cout 1; a=FFFFFFFF, b=0, cin=1 gives sum 0, cout 1; a=0, b=0, cin=0 gives sum 0, cout 0.
REQ-036 All four valid continuously after reset, rsp_ready=1 -> grants in order 0,1,2,3,0, one every 3 cycles, each sum correct.
REQ-037 Valid on requesters 1 and 3 only, rr_ptr=2 -> requester 3 served first, then 1.
REQ-038 rsp_ready held low for 5 cycles in RESP, other requesters valid -> rsp fields stable and req_ready stays 0 throughout; next grant follows the handshake.
REQ-039 rst pulsed during EXEC -> no rsp_valid; next cycle IDLE with rr_ptr 0; requester 2 still valid is granted in the first post-reset IDLE cycle.

Source files
------------

// File: rtl/add_arbiter.sv
// Four-requester round-robin front end time-sharing one ripple-carry adder.
// A request is accepted in IDLE, added in EXEC and held in RESP until the consumer takes it.

module add_all #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic carry;

  always_comb begin
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < N; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

module add_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q;
  logic [1:0]   rr_ptr_q;
  logic [N-1:0] a_q, b_q, sum_q;
  logic         cin_q, cout_q, rsp_valid_q;
  logic [1:0]   id_q;

  logic         grant_valid_d;
  logic [1:0]   grant_id_d;
  logic [1:0]   idx;
  logic         accept;
  logic [N-1:0] a_sel, b_sel;
  logic         cin_sel;
  logic [N-1:0] add_sum;
  logic         add_cout;

  // Scan starts at rr_ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    grant_valid_d = 1'b0;
    grant_id_d    = '0;
    idx           = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!grant_valid_d && req_valid[idx]) begin
        grant_valid_d = 1'b1;
        grant_id_d    = idx;
      end
    end
  end

  assign accept = (state_q == IDLE) && !rst && grant_valid_d;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id_d] = 1'b1;
  end

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_d == 2'(i)) begin
        a_sel   = req_a[i*N +: N];
        b_sel   = req_b[i*N +: N];
        cin_sel = req_cin[i];
      end
    end
  end

  add_all #(.N(N)) u_add (
    .a_i    (a_q),
    .b_i    (b_q),
    .cin_i  (cin_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a_sel;
            b_q     <= b_sel;
            cin_q   <= cin_sel;
            id_q    <= grant_id_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          sum_q       <= add_sum;
          cout_q      <= add_cout;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= id_q + 2'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin/arithmetic model.

module tb_add_arbiter;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [4*N-1:0] req_a, req_b;
  logic [3:0]     req_cin;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [N-1:0]   rsp_sum;
  logic           rsp_cout, busy;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;

  add_arbiter #(.N(N), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant(input logic [3:0] v, input int ptr);
    for (int i = 0; i < 4; i++)
      if (v[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  function automatic logic [N:0] exp_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
  endfunction

  function automatic logic [N-1:0] rnd_op();
    case ($urandom_range(3))
      0:       return '1;
      1:       return '0;
      default: return $urandom;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic c);
    req_a[k*N +: N] = a;
    req_b[k*N +: N] = b;
    req_cin[k]      = c;
  endtask

  function automatic logic [N:0] lane_sum(input int k);
    return exp_add(req_a[k*N +: N], req_b[k*N +: N], req_cin[k]);
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) set_lane(k, $urandom, $urandom, 1'b1);
    next_cycle(); next_cycle();
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (rsp_sum !== '0 || rsp_id !== 2'd0 || rsp_cout !== 1'b0) begin
      n_err++; $display("FAIL reset_rsp_fields got id %0d sum %h cout %b want 0 0 0", rsp_id, rsp_sum, rsp_cout);
    end
    next_cycle();
    rst = 1'b0; req_valid = 4'b0; m_ptr = 0;
  endtask

  task automatic test_basic();
    set_lane(0, 32'd5, 32'd7, 1'b0);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL basic_ready got %b want 0001", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy got %b want 0", busy); end
    next_cycle();
    req_valid = 4'b0; set_lane(0, $urandom, $urandom, 1'b1);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || req_ready !== 4'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_exec got busy %b ready %b rv %b want 1 0000 0", busy, req_ready, rsp_valid);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'd12 || rsp_cout !== 1'b0) begin
      n_err++; $display("FAIL basic_rsp got v %b id %0d sum %0d cout %b want 1 0 12 0", rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_after got rv %b busy %b want 0 0", rsp_valid, busy);
    end
    m_ptr = 1;
    next_cycle();
  endtask

  task automatic test_boundary();
    logic [N-1:0] ta [3];
    logic [N-1:0] tb [3];
    logic         tc [3];
    logic         ec [3];
    int k;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd1; tc[0] = 1'b0; ec[0] = 1'b1;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'd0; tc[1] = 1'b1; ec[1] = 1'b1;
    ta[2] = 32'd0;         tb[2] = 32'd0; tc[2] = 1'b0; ec[2] = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      k = m_ptr;
      set_lane(k, ta[i], tb[i], tc[i]);
      req_valid = 4'(1 << k);
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'(1 << k)) begin n_err++; $display("FAIL bnd_ready[%0d] got %b want %b", i, req_ready, 4'(1 << k)); end
      next_cycle(); req_valid = 4'b0;
      next_cycle();
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'd0 || rsp_cout !== ec[i]) begin
        n_err++; $display("FAIL bnd_sum[%0d] got v %b sum %h cout %b want 1 0 %b", i, rsp_valid, rsp_sum, rsp_cout, ec[i]);
      end
      next_cycle();
      m_ptr = (k + 1) % 4;
    end
  endtask

  task automatic test_round_robin();
    logic [N:0] e;
    int g;
    rst = 1'b1; req_valid = 4'b0;
    next_cycle();
    rst = 1'b0; m_ptr = 0; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) set_lane(k, rnd_op(), rnd_op(), 1'($urandom_range(1)));
    req_valid = 4'hF;
    for (int t = 0; t < 5; t++) begin
      g = t % 4;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'(1 << g)) begin n_err++; $display("FAIL rr_grant[%0d] got %b want %b", t, req_ready, 4'(1 << g)); end
      e = lane_sum(g);
      next_cycle();
      set_lane(g, rnd_op(), rnd_op(), 1'($urandom_range(1)));
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rr_exec_ready[%0d] got %b want 0000", t, req_ready); end
      next_cycle();
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || {rsp_cout, rsp_sum} !== e) begin
        n_err++; $display("FAIL rr_rsp[%0d] got v %b id %0d cs %h want 1 %0d %h", t, rsp_valid, rsp_id, {rsp_cout, rsp_sum}, g, e);
      end
      next_cycle();
      m_ptr = (g + 1) % 4;
    end
    req_valid = 4'b0;
  endtask

  task automatic test_skip();
    logic [N:0] e;
    int order [2];
    order[0] = 3; order[1] = 1;
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL skip_setup got %b want 0010", req_ready); end
    next_cycle(); req_valid = 4'b0;
    next_cycle(); next_cycle();
    m_ptr = 2;
    set_lane(1, rnd_op(), rnd_op(), 1'b1);
    set_lane(3, rnd_op(), rnd_op(), 1'b0);
    req_valid = 4'b1010;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'(1 << order[j])) begin n_err++; $display("FAIL skip_grant[%0d] got %b want %b", j, req_ready, 4'(1 << order[j])); end
      e = lane_sum(order[j]);
      next_cycle(); req_valid[order[j]] = 1'b0;
      next_cycle();
      @(negedge clk);
      n_cmp++; if (rsp_id !== 2'(order[j]) || {rsp_cout, rsp_sum} !== e) begin
        n_err++; $display("FAIL skip_rsp[%0d] got id %0d cs %h want %0d %h", j, rsp_id, {rsp_cout, rsp_sum}, order[j], e);
      end
      next_cycle();
    end
    m_ptr = 2;
  endtask

  task automatic test_backpressure();
    logic [N:0] e;
    set_lane(0, rnd_op(), rnd_op(), 1'b1);
    set_lane(2, rnd_op(), rnd_op(), 1'b0);
    req_valid = 4'b0101; rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_grant got %b want 0100", req_ready); end
    e = lane_sum(2);
    next_cycle(); req_valid = 4'b0001;
    next_cycle();
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || {rsp_cout, rsp_sum} !== e || req_ready !== 4'b0) begin
        n_err++; $display("FAIL bp_hold[%0d] got v %b id %0d cs %h rdy %b want 1 2 %h 0000", h, rsp_valid, rsp_id, {rsp_cout, rsp_sum}, req_ready, e);
      end
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0) begin
      n_err++; $display("FAIL bp_handshake got v %b rdy %b want 1 0000", rsp_valid, req_ready);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_next_grant got %b want 0001", req_ready); end
    next_cycle(); req_valid = 4'b0;
    next_cycle(); next_cycle();
    m_ptr = 1;
  endtask

  task automatic test_reset_exec();
    logic [N:0] e;
    rsp_ready = 1'b1;
    set_lane(2, rnd_op(), rnd_op(), 1'b0);
    req_valid = 4'b0100;
    next_cycle(); req_valid = 4'b0;
    next_cycle(); next_cycle();
    m_ptr = 3;
    set_lane(2, rnd_op(), rnd_op(), 1'b1);
    req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rx_first_grant got %b want 0100", req_ready); end
    next_cycle();
    rst = 1'b1;
    set_lane(3, rnd_op(), rnd_op(), 1'b0);
    req_valid = 4'b1100;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rx_ready_in_rst got %b want 0000", req_ready); end
    next_cycle();
    rst = 1'b0; m_ptr = 0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rx_abandon got rv %b busy %b want 0 0", rsp_valid, busy);
    end
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rx_regrant got %b want 0100", req_ready); end
    e = lane_sum(2);
    next_cycle(); req_valid = 4'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || {rsp_cout, rsp_sum} !== e) begin
      n_err++; $display("FAIL rx_rsp got v %b id %0d cs %h want 1 2 %h", rsp_valid, rsp_id, {rsp_cout, rsp_sum}, e);
    end
    next_cycle();
    m_ptr = 3;
  endtask

  task automatic test_random();
    logic [3:0] pend;
    logic [3:0] exp_rdy;
    logic [N:0] eres;
    logic       inflight, exp_rv;
    int acc, eid, g, acc_lane;
    pend = 4'b0; inflight = 1'b0; acc = 0; eid = 0; eres = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && $urandom_range(3) == 0) begin
          pend[k] = 1'b1;
          set_lane(k, rnd_op(), rnd_op(), 1'($urandom_range(1)));
        end else if (pend[k] && $urandom_range(15) == 0) begin
          pend[k] = 1'b0;
        end
      end
      req_valid = pend;
      rsp_ready = 1'($urandom_range(1));
      rst       = ($urandom_range(199) == 0);
      @(negedge clk);
      g       = exp_grant(req_valid, m_ptr);
      exp_rdy = (!rst && !inflight && g >= 0) ? 4'(1 << g) : 4'b0;
      exp_rv  = inflight && (cyc >= acc + 2);
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready@%0d got %b want %b", cyc, req_ready, exp_rdy); end
      n_cmp++; if (busy !== inflight) begin n_err++; $display("FAIL rnd_busy@%0d got %b want %b", cyc, busy, inflight); end
      n_cmp++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL rnd_rsp_valid@%0d got %b want %b", cyc, rsp_valid, exp_rv); end
      if (exp_rv) begin
        n_cmp++; if (rsp_id !== 2'(eid) || {rsp_cout, rsp_sum} !== eres) begin
          n_err++; $display("FAIL rnd_rsp@%0d got id %0d cs %h want %0d %h", cyc, rsp_id, {rsp_cout, rsp_sum}, eid, eres);
        end
      end
      acc_lane = -1;
      if (rst) begin
        inflight = 1'b0; m_ptr = 0;
      end else if (exp_rdy != 4'b0) begin
        inflight = 1'b1; acc = cyc; eid = g; eres = lane_sum(g);
        pend[g] = 1'b0; acc_lane = g;
      end else if (exp_rv && rsp_ready) begin
        inflight = 1'b0; m_ptr = (eid + 1) % 4;
      end
      next_cycle();
      if (acc_lane >= 0) set_lane(acc_lane, $urandom, $urandom, 1'($urandom_range(1)));
    end
    rst = 1'b1; req_valid = 4'b0;
    next_cycle();
    rst = 1'b0; m_ptr = 0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_cin = 4'b0;
    test_reset();
    test_basic();
    test_boundary();
    test_round_robin();
    test_skip();
    test_backpressure();
    test_reset_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
